// File: rtl/dma_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_bus_arbiter_pkg
// Purpose  : Shared types and constants for the DMA bus arbiter: FSM state
//            encoding, byte/word unit codes, address increments and the
//            word-alignment helper.
// Config   : DMA_CYCLE_STEAL_EN adds the ST_YIELD state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package dma_bus_arbiter_pkg;

    // Transfer unit encoding, matching the CPU BW convention.
    localparam logic BYTE = 1'b1;
    localparam logic WORD = 1'b0;

    // Address step per transfer.
    localparam logic [15:0] INC_BYTE = 16'd1;
    localparam logic [15:0] INC_WORD = 16'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR    = 3'd2,
`ifdef DMA_CYCLE_STEAL_EN
        ST_YIELD = 3'd3,
`endif
        ST_DONE  = 3'd4
    } dma_state_t;

    // Word accesses always go to an even address; the raw register keeps its
    // LSB so only the presented address is aligned.
    function automatic logic [15:0] align_addr(input logic [15:0] addr,
                                               input logic        bw);
        return (bw == BYTE) ? addr : {addr[15:1], 1'b0};
    endfunction

endpackage : dma_bus_arbiter_pkg
`default_nettype wire

// File: rtl/dma_bus_arbiter_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : dma_bus_arbiter_addr_gen
// Purpose  : Source/destination address registers of the DMA engine.
//            'load' latches the start addresses and transfer unit; 'step'
//            advances both addresses by one unit (mod 2^16). Presented
//            addresses are word-aligned when the unit is a word.
// Ports    : MCLK, RSTn (sync, active-low), load, step, src_in, dst_in,
//            bw_in -> src_addr, dst_addr, bw
// Revision : 1.0 - initial release
// ============================================================================
module dma_bus_arbiter_addr_gen
    import dma_bus_arbiter_pkg::*;
(
    input  logic        MCLK,
    input  logic        RSTn,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] src_in,
    input  logic [15:0] dst_in,
    input  logic        bw_in,
    output logic [15:0] src_addr,
    output logic [15:0] dst_addr,
    output logic        bw
);

    logic [15:0] src_reg;
    logic [15:0] dst_reg;
    logic        bw_reg;
    logic [15:0] inc;

    assign inc = (bw_reg == BYTE) ? INC_BYTE : INC_WORD;

    always_ff @(posedge MCLK) begin
        if (!RSTn) begin
            src_reg <= 16'h0000;
            dst_reg <= 16'h0000;
            bw_reg  <= WORD;
        end else if (load) begin
            src_reg <= src_in;
            dst_reg <= dst_in;
            bw_reg  <= bw_in;
        end else if (step) begin
            // Natural 16-bit overflow gives the required wrap to 0x0000.
            src_reg <= src_reg + inc;
            dst_reg <= dst_reg + inc;
        end
    end

    assign src_addr = align_addr(src_reg, bw_reg);
    assign dst_addr = align_addr(dst_reg, bw_reg);
    assign bw       = bw_reg;

endmodule : dma_bus_arbiter_addr_gen
`default_nettype wire

// File: rtl/dma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dma_bus_arbiter
// Purpose  : Shares the system bus between the CPU and a single-channel DMA
//            block-transfer engine. A request is granted only at a CPU
//            instruction boundary; the engine then runs read/write pairs
//            and returns the bus with a one-cycle dma_done pulse.
// Ports    : MCLK, RSTn (sync, active-low)
//            cpu_MAB/cpu_MDBout/cpu_BW/cpu_MW/cpu_sync  - CPU bus side
//            MDBin                                      - memory read data
//            dma_req/dma_src/dma_dst/dma_bw/dma_cnt     - DMA request
//            MAB/MDBout/BW/MW                           - shared bus
//            cpu_hold, dma_busy, dma_done               - status
// Config   : DMA_CYCLE_STEAL_EN - return the bus to the CPU between
//            transfers (YIELD state) instead of bursting.
// Revision : 1.0 - initial release
// ============================================================================
module dma_bus_arbiter
    import dma_bus_arbiter_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             MCLK,
    input  logic             RSTn,
    input  logic [15:0]      cpu_MAB,
    input  logic [15:0]      cpu_MDBout,
    input  logic             cpu_BW,
    input  logic             cpu_MW,
    input  logic             cpu_sync,
    input  logic [15:0]      MDBin,
    input  logic             dma_req,
    input  logic [15:0]      dma_src,
    input  logic [15:0]      dma_dst,
    input  logic             dma_bw,
    input  logic [CNT_W-1:0] dma_cnt,
    output logic [15:0]      MAB,
    output logic [15:0]      MDBout,
    output logic             BW,
    output logic             MW,
    output logic             cpu_hold,
    output logic             dma_busy,
    output logic             dma_done
);

    dma_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_dec;
    logic [15:0]      data;
    logic             grant;
    logic             load;
    logic             step;
    logic [15:0]      src_addr;
    logic [15:0]      dst_addr;
    logic             xfer_bw;

    assign grant   = (state == ST_IDLE) && dma_req && cpu_sync;
    assign load    = grant && (dma_cnt != '0);
    assign step    = (state == ST_WR);
    assign cnt_dec = cnt - CNT_W'(1);

    dma_bus_arbiter_addr_gen u_addr_gen (
        .MCLK     (MCLK),
        .RSTn     (RSTn),
        .load     (load),
        .step     (step),
        .src_in   (dma_src),
        .dst_in   (dma_dst),
        .bw_in    (dma_bw),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .bw       (xfer_bw)
    );

    always_ff @(posedge MCLK) begin
        if (!RSTn) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            data     <= 16'h0000;
            cpu_hold <= 1'b0;
            dma_done <= 1'b0;
        end else begin
            dma_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        if (dma_cnt != '0) begin
                            cnt      <= dma_cnt;
                            cpu_hold <= 1'b1;
                            state    <= ST_RD;
                        end else begin
                            // Empty request: acknowledge without touching the bus.
                            dma_done <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_RD: begin
                    data  <= (xfer_bw == BYTE) ? {8'h00, MDBin[7:0]} : MDBin;
                    state <= ST_WR;
                end
                ST_WR: begin
                    cnt <= cnt_dec;
                    if (cnt_dec == '0) begin
                        // Release the CPU as DONE is entered so the DONE cycle
                        // already runs as a CPU cycle.
                        cpu_hold <= 1'b0;
                        dma_done <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
`ifdef DMA_CYCLE_STEAL_EN
                        cpu_hold <= 1'b0;
                        state    <= ST_YIELD;
`else
                        state    <= ST_RD;
`endif
                    end
                end
`ifdef DMA_CYCLE_STEAL_EN
                ST_YIELD: begin
                    // Only re-stall the CPU at an instruction boundary.
                    if (cpu_sync) begin
                        cpu_hold <= 1'b1;
                        state    <= ST_RD;
                    end
                end
`endif
                ST_DONE: begin
                    cpu_hold <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    cpu_hold <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus mux: the engine owns the bus only in RD and WR; every other state
    // is a plain CPU pass-through.
    always_comb begin
        MAB    = cpu_MAB;
        MDBout = cpu_MDBout;
        BW     = cpu_BW;
        MW     = cpu_MW;
        case (state)
            ST_RD: begin
                MAB    = src_addr;
                MDBout = 16'h0000;
                BW     = xfer_bw;
                MW     = 1'b0;
            end
            ST_WR: begin
                MAB    = dst_addr;
                MDBout = (xfer_bw == BYTE) ? {8'h00, data[7:0]} : data;
                BW     = xfer_bw;
                MW     = 1'b1;
            end
            default: ;
        endcase
    end

    assign dma_busy = (state != ST_IDLE);

endmodule : dma_bus_arbiter
`default_nettype wire
